aes_main: RTL and testbench
===========================

Name: aes_main

Overview:
- AES-128 (FIPS-197) block that encrypts a 128-bit plaintext under a 128-bit key, then decrypts its own ciphertext with the same key, and presents both results.
- Used as a self-checking crypto core: after a correct run, `decrypt` equals the captured `data`.
- Iterative architecture: one round per clock, with on-the-fly key expansion forward for encryption and inverse key expansion backward for decryption.

Parameters:
- None. Block size and key size are fixed at 128 bits; Nr = 10.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  1-cycle request; sampled only when `busy`=0
- `data`  in  128  plaintext; bit 127 is byte 0 of the FIPS state (MSB-first byte order)
- `key`  in  128  cipher key, same byte order
- `busy`  out  1  high from the accepting edge until `done`
- `cipher_valid`  out  1  1-cycle pulse when `cipher` is updated
- `cipher`  out  128  ciphertext register
- `done`  out  1  1-cycle pulse when `decrypt` is updated
- `decrypt`  out  128  decrypted-text register

Behaviour:
- **Reset** (asynchronous, while `rst`=1): all of `busy`, `cipher_valid`, `done`, `cipher` and `decrypt` are 0. Internal state, round key and counter are cleared; the FSM goes to IDLE.
- **FSM states:** IDLE, ENC, DEC.
- **Start:** `start`=1 in IDLE at edge E0:
  - state <= `data` ^ `key`; round key <= `key`; round = 1;
  - `busy` <= 1; FSM goes to ENC.
  - `data` and `key` are captured at E0; later changes have no effect.
- **ENC, edges E1..E10:**
  - next round key = KeyExpansion step (RotWord, SubWord, Rcon = 01,02,04,08,10,20,40,80,1b,36).
  - Rounds 1–9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10: no MixColumns.
  - At E10: `cipher` <= round-10 result; `cipher_valid`=1 for exactly the cycle after E10; internal state <= result ^ rk10 (initial inverse AddRoundKey is absorbed here); FSM goes to DEC.
- **DEC, edges E11..E20:**
  - Round keys are regenerated backward, rk10 → rk0, by inverse key expansion using the same Rcon in reverse.
  - Each step: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns for all but the last step.
  - At E20: `decrypt` <= result; `done`=1 for exactly the cycle after E20; `busy` <= 0; FSM goes to IDLE.
- **Latency:** `cipher` is available 10 edges after acceptance; `decrypt` 20 edges after acceptance.
- **Busy interaction:** `start` while `busy`=1 is ignored, with no queueing.
- **Back-to-back runs:** `start` in the same cycle `done` is high is accepted, because `busy` is already 0 in that cycle.
- **Output holding:** `cipher` and `decrypt` hold their values between runs. `cipher` updates at E10 while `decrypt` still holds the previous run's value until E20.
- **Reset mid-run:** aborts immediately; all outputs go to 0 and no pulse is issued.
- **S-box / inverse S-box:** implementation is free (LUT or GF(2^8) inversion plus affine map), provided it is bit-exact to FIPS-197.
- **GF arithmetic:** xtime reduction uses polynomial 0x11b.

Test Plan:
- **FIPS-197 C.1 vector:** reset, then `start` with `key`=000102030405060708090a0b0c0d0e0f, `data`=00112233445566778899aabbccddeeff → `cipher`=69c4e0d86a7b0430d8cdb78070b4c55a with `cipher_valid` the cycle after E10; `decrypt`=00112233445566778899aabbccddeeff with `done` the cycle after E20.
- **FIPS-197 Appendix B vector:** `key`=2b7e151628aed2a6abf7158809cf4f3c, `data`=3243f6a8885a308d313198a2e0370734 → `cipher`=3925841d02dc09fbdc118597196a0b32; `decrypt` equals `data`.
- **Arbitrary round-trip:** `data`=aaeabaaeabaaeabaaeabaaeabaaeabaa, `key`=f1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1 → `cipher` matches a software AES-128 model; `decrypt`=aaeabaaeabaaeabaaeabaaeabaaeabaa.
- **Busy and capture:** pulse `start` again and change `data`/`key` mid-run → results match the first captured inputs; `busy` stays high for exactly 20 cycles.
- **Async reset mid-run:** assert `rst` at E5 between clock edges → all outputs read 0 immediately; a new `start` after release produces correct results.
- **Back-to-back and all-zero vector:** `start` asserted in the `done` cycle with all-zero `key`/`data` → `cipher`=66e94bd4ef8a2c3b884cfa59ca342b2e and `decrypt`=0.

Source files
------------

// File: rtl/aes_main_if.sv
// ---------------------------------------------------------------------------
// aes_main_if : bus bundle for the aes_main encrypt/decrypt round-trip core.
//
// Signals
//   start        1   request pulse (driven by master)
//   data       128   plaintext, bit 127 = state byte 0 (driven by master)
//   key        128   cipher key, same byte order (driven by master)
//   busy         1   core is running a job (driven by slave)
//   cipher_valid 1   one-cycle pulse, cipher just updated (driven by slave)
//   cipher     128   ciphertext register (driven by slave)
//   done         1   one-cycle pulse, decrypt just updated (driven by slave)
//   decrypt    128   decrypted-text register (driven by slave)
//   dbg_state    2   current FSM state, for observation only (driven by slave)
//
// Handshake: start is sampled on a rising edge only while busy is low, and
// data/key are captured on that same edge. There is no back-pressure:
// cipher_valid and done are single-cycle pulses that the master must catch.
// ---------------------------------------------------------------------------
interface aes_main_if;
  logic         start;
  logic [127:0] data;
  logic [127:0] key;
  logic         busy;
  logic         cipher_valid;
  logic [127:0] cipher;
  logic         done;
  logic [127:0] decrypt;
  logic [1:0]   dbg_state;

  modport master (
    output start, data, key,
    input  busy, cipher_valid, cipher, done, decrypt, dbg_state
  );

  modport slave (
    input  start, data, key,
    output busy, cipher_valid, cipher, done, decrypt, dbg_state
  );
endinterface

// File: rtl/aes_main.sv
// ---------------------------------------------------------------------------
// aes_main : iterative AES-128 core. Encrypts the captured plaintext (one
// round per clock, key schedule expanded forward on the fly), then decrypts
// its own ciphertext (key schedule unwound backward from rk10 to rk0).
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  aes_main_if.slave: start/data/key in; busy, cipher_valid, cipher,
//        done, decrypt, dbg_state out
//
// Timing: accept at E0, cipher written at E10, decrypt written at E20.
// ---------------------------------------------------------------------------
module aes_main (
  input  logic      clk,
  input  logic      rst,
  aes_main_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, DEC = 2'd2} state_t;

  state_t       r_state, w_state_nxt;
  logic [127:0] r_blk, r_rk, r_cipher, r_decrypt;
  logic [3:0]   r_round;
  logic         r_cipher_valid, r_done;

  logic [127:0] w_rk_fwd, w_sb_sr, w_enc_out;
  logic [127:0] w_rk_bwd, w_dec_ark, w_dec_out;

  // ---------------- GF(2^8) helpers (polynomial 0x11b) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and maps 0 to 0): square-and-multiply over exponents 2..128
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // ---------------- state transforms (byte n at bits 127-8n) ----------------
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  // Both matrices are circulant; row r uses coefficient m[(k-r) mod 4] on a[k].
  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] o;
    o = '0;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(k+4*c) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gf_mul(m[(k-r+4)%4], a[k]);
        o[127-8*(r+4*c) -: 8] = b;
      end
    end
    return o;
  endfunction

  // ---------------- key schedule ----------------
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // rk(idx-1) -> rk(idx)
  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon(idx), 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk(idx) -> rk(idx-1); w3 is recovered first because w0 depends on it.
  function automatic logic [127:0] key_bwd(input logic [127:0] rk, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0]  ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rcon(idx), 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- round datapath ----------------
  // r_round holds the index of the round key being produced (ENC) or the
  // index of the key currently held in r_rk (DEC).
  always_comb begin
    w_rk_fwd  = key_fwd(r_rk, r_round);
    w_sb_sr   = sub_shift(r_blk);
    w_enc_out = ((r_round == 4'd10) ? w_sb_sr : mix_cols(w_sb_sr, 1'b0)) ^ w_rk_fwd;
    w_rk_bwd  = key_bwd(r_rk, r_round);
    w_dec_ark = inv_shift_sub(r_blk) ^ w_rk_bwd;
    w_dec_out = (r_round == 4'd1) ? w_dec_ark : mix_cols(w_dec_ark, 1'b1);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = ENC;
      ENC:     if (r_round == 4'd10) w_state_nxt = DEC;
      DEC:     if (r_round == 4'd1) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk          <= '0;
      r_rk           <= '0;
      r_round        <= '0;
      r_cipher       <= '0;
      r_decrypt      <= '0;
      r_cipher_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_cipher_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_blk   <= bus.data ^ bus.key;
            r_rk    <= bus.key;
            r_round <= 4'd1;
          end
        end
        ENC: begin
          r_rk <= w_rk_fwd;
          if (r_round == 4'd10) begin
            r_cipher       <= w_enc_out;
            r_cipher_valid <= 1'b1;
            // Fold the first inverse AddRoundKey (rk10) into the hand-over;
            // r_round stays 10 so DEC starts unwinding from rk10.
            r_blk          <= w_enc_out ^ w_rk_fwd;
          end else begin
            r_blk   <= w_enc_out;
            r_round <= r_round + 4'd1;
          end
        end
        DEC: begin
          r_rk    <= w_rk_bwd;
          r_blk   <= w_dec_out;
          r_round <= r_round - 4'd1;
          if (r_round == 4'd1) begin
            r_decrypt <= w_dec_out;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.cipher_valid = r_cipher_valid;
  assign bus.cipher       = r_cipher;
  assign bus.done         = r_done;
  assign bus.decrypt      = r_decrypt;
  assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_aes_main.sv
// ---------------------------------------------------------------------------
// tb_aes_main : self-checking bench for aes_main. Expected ciphertext comes
// from known-answer constants or a byte-level software AES-128 model;
// expected decrypt is the plaintext that was submitted.
// ---------------------------------------------------------------------------
module tb_aes_main;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_main_if bus ();

  aes_main dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_cipher_q[$];
  logic [127:0] exp_dec_q[$];
  logic [127:0] prev_dec;
  logic [7:0]   m_sbox [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Walk p over the multiplicative group by powers of 3 while q tracks 1/p.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      m_sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    m_sbox[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   rc, a0, a1, a2, a3, t;
    logic [31:0]  tw;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {m_sbox[tw[23:16]], m_sbox[tw[15:8]], m_sbox[tw[7:0]], m_sbox[tw[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++) st[i] = d[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) tmp[i] = m_sbox[st[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          t = a0 ^ a1 ^ a2 ^ a3;
          st[4*c]   = a0 ^ t ^ xt(a0 ^ a1);
          st[4*c+1] = a1 ^ t ^ xt(a1 ^ a2);
          st[4*c+2] = a2 ^ t ^ xt(a2 ^ a3);
          st[4*c+3] = a3 ^ t ^ xt(a3 ^ a0);
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cipher_valid) begin
        if (exp_cipher_q.size() == 0) check_bit("cipher_unexpected", bus.cipher_valid, 1'b0);
        else check("cipher", bus.cipher, exp_cipher_q.pop_front());
      end
      if (bus.done) begin
        if (exp_dec_q.size() == 0) check_bit("done_unexpected", bus.done, 1'b0);
        else check("decrypt", bus.decrypt, exp_dec_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Negedge n after acceptance lies between E(n-1) and E(n).
  task automatic wait_run(input bit disturb, input logic [127:0] c_exp);
    int n;
    bit got_done;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 40) begin
      @(negedge clk);
      n++;
      check_bit("busy", bus.busy, (n <= 20));
      check_bit("cipher_valid_timing", bus.cipher_valid, (n == 11));
      check_bit("done_timing", bus.done, (n == 21));
      if (n == 11) check("decrypt_hold", bus.decrypt, prev_dec);
      if (n == 21) check("cipher_hold", bus.cipher, c_exp);
      if (disturb && n == 5) begin
        bus.start = 1'b1;
        bus.key   = rand128();
        bus.data  = rand128();
      end
      if (disturb && n == 6) bus.start = 1'b0;
      if (bus.done) got_done = 1'b1;
    end
    check_bit("run_complete", got_done, 1'b1);
  endtask

  // Called at a negedge while the core is idle; returns at the done cycle.
  task automatic do_run(input logic [127:0] k, input logic [127:0] d,
                        input logic [127:0] c_exp, input bit disturb);
    exp_cipher_q.push_back(c_exp);
    exp_dec_q.push_back(d);
    bus.start = 1'b1;
    bus.key   = k;
    bus.data  = d;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.key   = rand128();
    bus.data  = rand128();
    wait_run(disturb, c_exp);
    prev_dec = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k, d;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.key   = '0;
    prev_dec  = '0;
    rst       = 1'b1;
    build_sbox();
    #3;
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_cipher_valid", bus.cipher_valid, 1'b0);
    check_bit("rst_done", bus.done, 1'b0);
    check("rst_cipher", bus.cipher, '0);
    check("rst_decrypt", bus.decrypt, '0);
    check_bit("rst_state_idle", bus.dbg_state == 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    do_run(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
    repeat (2) @(negedge clk);
    do_run(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
           128'h3925841d02dc09fbdc118597196a0b32, 1'b1);
    @(negedge clk);
    k = 128'hf1fc7f1fc7f1fc7f1fc7f1fc7f1fc7f1;
    d = 128'haaeabaaeabaaeabaaeabaaeabaaeabaa;
    do_run(k, d, aes_ref(k, d), 1'b0);

    // Reset in the middle of encryption, between edges after E5.
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = rand128();
    bus.data  = rand128();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_bit("arst_busy", bus.busy, 1'b0);
    check_bit("arst_cipher_valid", bus.cipher_valid, 1'b0);
    check_bit("arst_done", bus.done, 1'b0);
    check("arst_cipher", bus.cipher, '0);
    check("arst_decrypt", bus.decrypt, '0);
    check_bit("arst_state_idle", bus.dbg_state == 2'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    prev_dec = '0;

    k = rand128();
    d = rand128();
    do_run(k, d, aes_ref(k, d), 1'b0);
    // Start in the done cycle: all-zero vector back-to-back.
    do_run('0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1'b0);

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      k = rand128();
      d = rand128();
      do_run(k, d, aes_ref(k, d), ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    check_bit("cipher_queue_drained", exp_cipher_q.size() == 0, 1'b1);
    check_bit("decrypt_queue_drained", exp_dec_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
